// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctrl_pkg
//  Description : Shared definitions for the AES encryption/decryption state
//                managers: FSM state encodings, matrix write-source select
//                codes and the AES-128 round count.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_ctrl_pkg;

    // AES-128 round count; the last round key index equals this value.
    localparam int NUM_ROUNDS = 10;

    // Decryption manager state encodings.
    typedef enum logic [5:0] {
        ST_IDLE              = 6'd0,
        ST_CTEXT_WRITE       = 6'd1,
        ST_KEY_WRITE         = 6'd2,
        ST_COMPUTE_ROUNDKEYS = 6'd3,
        ST_INIT_ADDROUNDKEY  = 6'd4,
        ST_INV_SHIFTROWS     = 6'd5,
        ST_INV_SUBBYTES      = 6'd6,
        ST_ADDROUNDKEY       = 6'd7,
        ST_INV_MIXCOLUMNS    = 6'd8,
        ST_DECRYPTION_DONE   = 6'd9,
        ST_PTEXT_READ        = 6'd10
    } aes_dec_state_e;

    // Matrix write-source select codes (forward codes used by the encryptor).
    localparam logic [3:0] MSEL_EXT = 4'd0;
    localparam logic [3:0] MSEL_SB  = 4'd1;
    localparam logic [3:0] MSEL_SR  = 4'd2;
    localparam logic [3:0] MSEL_MC  = 4'd3;
    localparam logic [3:0] MSEL_ARK = 4'd4;
    localparam logic [3:0] MSEL_ISB = 4'd5;
    localparam logic [3:0] MSEL_ISR = 4'd6;
    localparam logic [3:0] MSEL_IMC = 4'd7;

endpackage
`default_nettype wire

// File: rtl/aes_dec_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : aes_dec_state_manager
//  Description : Control FSM for the AES-128 inverse cipher. Sequences the
//                shared 4x4 state matrix through ciphertext/key load, key
//                expansion wait, initial AddRoundKey, the inverse rounds and
//                plaintext readout. All outputs decode the state registers.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_dec_state_manager #(
    parameter int NUM_ROUNDS = aes_ctrl_pkg::NUM_ROUNDS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_write_n,
    input  logic       start_read_n,
    input  logic       key_expand_done,
    output logic       done,
    output logic [5:0] dbg_state,
    output logic [3:0] dbg_round,
    output logic [3:0] matrix_in_sel,
    output logic       matrix_write_enable,
    output logic       input_mat_row_col,
    output logic [1:0] input_mat_idx,
    output logic       output_mat_row_col,
    output logic [1:0] output_mat_idx,
    output logic [3:0] round_key_idx,
    output logic       key_start,
    output logic [1:0] count_4_out
);
    import aes_ctrl_pkg::*;

    localparam logic [5:0] c_st_idle     = ST_IDLE;
    localparam logic [5:0] c_st_ctext    = ST_CTEXT_WRITE;
    localparam logic [5:0] c_st_key      = ST_KEY_WRITE;
    localparam logic [5:0] c_st_compute  = ST_COMPUTE_ROUNDKEYS;
    localparam logic [5:0] c_st_init_ark = ST_INIT_ADDROUNDKEY;
    localparam logic [5:0] c_st_isr      = ST_INV_SHIFTROWS;
    localparam logic [5:0] c_st_isb      = ST_INV_SUBBYTES;
    localparam logic [5:0] c_st_ark      = ST_ADDROUNDKEY;
    localparam logic [5:0] c_st_imc      = ST_INV_MIXCOLUMNS;
    localparam logic [5:0] c_st_done     = ST_DECRYPTION_DONE;
    localparam logic [5:0] c_st_ptext    = ST_PTEXT_READ;

    localparam logic [3:0] c_first_round = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] c_last_key    = 4'(NUM_ROUNDS);

    // Port-select encodings for the matrix row/column ports.
    localparam logic c_row = 1'b0;
    localparam logic c_col = 1'b1;

    logic [5:0] r_state;
    logic [3:0] r_round;
    logic [1:0] r_count_4;

    logic [5:0] w_state_nxt;
    logic [3:0] w_round_nxt;
    logic [1:0] w_count_4_nxt;
    logic       w_last_step;

    assign w_last_step = (r_count_4 == 2'd3);

    // State, round counter and 4-step counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_idle;
            r_round   <= 4'd0;
            r_count_4 <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_round   <= w_round_nxt;
            r_count_4 <= w_count_4_nxt;
        end
    end

    // Next-state logic; four-step states advance count_4 and leave on step 3,
    // where the 2-bit counter wraps back to 0 on its own.
    always_comb begin
        w_state_nxt   = r_state;
        w_round_nxt   = r_round;
        w_count_4_nxt = 2'd0;
        case (r_state)
            c_st_idle: begin
                if (!start_write_n) w_state_nxt = c_st_ctext;
            end
            c_st_ctext: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) w_state_nxt = c_st_key;
            end
            c_st_key: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) w_state_nxt = c_st_compute;
            end
            c_st_compute: begin
                if (key_expand_done) begin
                    w_state_nxt = c_st_init_ark;
                    w_round_nxt = c_first_round;
                end
            end
            c_st_init_ark: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) w_state_nxt = c_st_isr;
            end
            c_st_isr: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) w_state_nxt = c_st_isb;
            end
            c_st_isb: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) w_state_nxt = c_st_ark;
            end
            c_st_ark: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) begin
                    // Round 0 is the final round: it skips InvMixColumns.
                    w_state_nxt = (r_round == 4'd0) ? c_st_done : c_st_imc;
                end
            end
            c_st_imc: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) begin
                    w_state_nxt = c_st_isr;
                    w_round_nxt = r_round - 4'd1;
                end
            end
            c_st_done: begin
                if (!start_read_n) w_state_nxt = c_st_ptext;
            end
            c_st_ptext: begin
                w_count_4_nxt = r_count_4 + 2'd1;
                if (w_last_step) begin
                    w_state_nxt = c_st_idle;
                    w_round_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    // Output decode; anything not driven by the current state stays 0.
    always_comb begin
        done                = 1'b0;
        matrix_in_sel       = MSEL_EXT;
        matrix_write_enable = 1'b0;
        input_mat_row_col   = c_row;
        input_mat_idx       = 2'd0;
        output_mat_row_col  = c_row;
        output_mat_idx      = 2'd0;
        round_key_idx       = 4'd0;
        key_start           = 1'b0;
        case (r_state)
            c_st_ctext: begin
                matrix_in_sel       = MSEL_EXT;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_col;
                input_mat_idx       = r_count_4;
            end
            c_st_key: begin
                input_mat_row_col   = c_row;
                input_mat_idx       = r_count_4;
                key_start           = (r_count_4 == 2'd0);
            end
            c_st_init_ark: begin
                matrix_in_sel       = MSEL_ARK;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_col;
                input_mat_idx       = r_count_4;
                output_mat_row_col  = c_col;
                output_mat_idx      = r_count_4;
                round_key_idx       = c_last_key;
            end
            c_st_isr: begin
                matrix_in_sel       = MSEL_ISR;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_row;
                input_mat_idx       = r_count_4;
                output_mat_row_col  = c_row;
                output_mat_idx      = r_count_4;
            end
            c_st_isb: begin
                matrix_in_sel       = MSEL_ISB;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_row;
                input_mat_idx       = r_count_4;
                output_mat_row_col  = c_row;
                output_mat_idx      = r_count_4;
            end
            c_st_ark: begin
                matrix_in_sel       = MSEL_ARK;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_col;
                input_mat_idx       = r_count_4;
                output_mat_row_col  = c_col;
                output_mat_idx      = r_count_4;
                round_key_idx       = r_round;
            end
            c_st_imc: begin
                matrix_in_sel       = MSEL_IMC;
                matrix_write_enable = 1'b1;
                input_mat_row_col   = c_col;
                input_mat_idx       = r_count_4;
                output_mat_row_col  = c_col;
                output_mat_idx      = r_count_4;
            end
            c_st_done: begin
                done                = 1'b1;
            end
            c_st_ptext: begin
                output_mat_row_col  = c_col;
                output_mat_idx      = r_count_4;
            end
            default: begin
                done                = 1'b0;
            end
        endcase
    end

    assign dbg_state   = r_state;
    assign dbg_round   = r_round;
    assign count_4_out = r_count_4;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_dec_state_manager
//  Description : Scoreboard bench for the AES decryption state manager.
//                Stimulus pushes the hand-derived per-cycle output vector;
//                a negedge monitor pops and compares it with the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_dec_state_manager;

    typedef struct packed {
        logic [5:0] st;
        logic [3:0] rnd;
        logic [3:0] sel;
        logic       we;
        logic       irc;
        logic [1:0] iidx;
        logic       orc;
        logic [1:0] oidx;
        logic [3:0] rki;
        logic       ks;
        logic       dn;
        logic [1:0] c4;
    } out_t;

    logic       clock;
    logic       reset_n;
    logic       start_write_n;
    logic       start_read_n;
    logic       key_expand_done;
    logic       done;
    logic [5:0] dbg_state;
    logic [3:0] dbg_round;
    logic [3:0] matrix_in_sel;
    logic       matrix_write_enable;
    logic       input_mat_row_col;
    logic [1:0] input_mat_idx;
    logic       output_mat_row_col;
    logic [1:0] output_mat_idx;
    logic [3:0] round_key_idx;
    logic       key_start;
    logic [1:0] count_4_out;

    out_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    int   e0 = 0;
    int   done_cyc = -1;

    aes_dec_state_manager #(.NUM_ROUNDS(10)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start_write_n       (start_write_n),
        .start_read_n        (start_read_n),
        .key_expand_done     (key_expand_done),
        .done                (done),
        .dbg_state           (dbg_state),
        .dbg_round           (dbg_round),
        .matrix_in_sel       (matrix_in_sel),
        .matrix_write_enable (matrix_write_enable),
        .input_mat_row_col   (input_mat_row_col),
        .input_mat_idx       (input_mat_idx),
        .output_mat_row_col  (output_mat_row_col),
        .output_mat_idx      (output_mat_idx),
        .round_key_idx       (round_key_idx),
        .key_start           (key_start),
        .count_4_out         (count_4_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Expected outputs for one cycle, straight from the state output table.
    function automatic out_t exp_of(input logic [5:0] st, input logic [3:0] rnd,
                                    input logic [1:0] c);
        out_t e;
        e     = '0;
        e.st  = st;
        e.rnd = rnd;
        e.c4  = c;
        case (st)
            6'd1: begin e.sel = 4'd0; e.we = 1; e.irc = 1; e.iidx = c; end
            6'd2: begin e.iidx = c; e.ks = (c == 2'd0); end
            6'd4: begin e.sel = 4'd4; e.we = 1; e.irc = 1; e.iidx = c;
                        e.orc = 1; e.oidx = c; e.rki = 4'd10; end
            6'd5: begin e.sel = 4'd6; e.we = 1; e.iidx = c; e.oidx = c; end
            6'd6: begin e.sel = 4'd5; e.we = 1; e.iidx = c; e.oidx = c; end
            6'd7: begin e.sel = 4'd4; e.we = 1; e.irc = 1; e.iidx = c;
                        e.orc = 1; e.oidx = c; e.rki = rnd; end
            6'd8: begin e.sel = 4'd7; e.we = 1; e.irc = 1; e.iidx = c;
                        e.orc = 1; e.oidx = c; end
            6'd9: begin e.dn = 1; end
            6'd10: begin e.orc = 1; e.oidx = c; end
            default: begin e.c4 = c; end
        endcase
        return e;
    endfunction

    // Monitor: every negedge with a pending expectation is compared.
    always @(negedge clock) begin
        out_t a;
        out_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{dbg_state, dbg_round, matrix_in_sel, matrix_write_enable,
                  input_mat_row_col, input_mat_idx, output_mat_row_col,
                  output_mat_idx, round_key_idx, key_start, done, count_4_out};
            total = total + 1;
            if (a !== e) begin
                bad = bad + 1;
                $display("FAIL outputs cyc=%0d got st=%0d rnd=%0d (%h) want st=%0d rnd=%0d (%h)",
                         cyc_cnt, a.st, a.rnd, a, e.st, e.rnd, e);
            end
            if (a.st == 6'd9 && done_cyc < 0) done_cyc = cyc_cnt;
        end
    end

    task automatic cyc(input out_t e);
        @(posedge clock);
        #1;
        sb.push_back(e);
    endtask

    task automatic phase(input logic [5:0] st, input logic [3:0] rnd);
        for (int c = 0; c < 4; c++) cyc(exp_of(st, rnd, 2'(c)));
    endtask

    // Ciphertext/key write, key-expansion stall, and the initial AddRoundKey.
    task automatic load_and_init(input bit spurious);
        start_write_n = 1'b0;
        cyc(exp_of(6'd1, 4'd0, 2'd0));
        start_write_n = 1'b1;
        if (spurious) begin
            start_read_n    = 1'b0;
            key_expand_done = 1'b1;
        end
        for (int c = 1; c < 4; c++) cyc(exp_of(6'd1, 4'd0, 2'(c)));
        start_read_n    = 1'b1;
        key_expand_done = 1'b0;
        phase(6'd2, 4'd0);
        for (int i = 0; i < 20; i++) cyc(exp_of(6'd3, 4'd0, 2'd0));
        key_expand_done = 1'b1;
        cyc(exp_of(6'd4, 4'd9, 2'd0));
        e0              = cyc_cnt;
        done_cyc        = -1;
        key_expand_done = 1'b0;
        for (int c = 1; c < 4; c++) cyc(exp_of(6'd4, 4'd9, 2'(c)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n         = 1'b0;
        start_write_n   = 1'b1;
        start_read_n    = 1'b1;
        key_expand_done = 1'b0;
        for (int i = 0; i < 3; i++) cyc(exp_of(6'd0, 4'd0, 2'd0));
        reset_n         = 1'b1;
        key_expand_done = 1'b1;
        start_read_n    = 1'b0;
        for (int i = 0; i < 2; i++) cyc(exp_of(6'd0, 4'd0, 2'd0));
        key_expand_done = 1'b0;
        start_read_n    = 1'b1;

        // Run A: aborted by reset in the middle of round 5 InvSubBytes.
        load_and_init(1'b0);
        for (int r = 9; r >= 6; r--) begin
            phase(6'd5, 4'(r));
            phase(6'd6, 4'(r));
            phase(6'd7, 4'(r));
            phase(6'd8, 4'(r));
        end
        phase(6'd5, 4'd5);
        cyc(exp_of(6'd6, 4'd5, 2'd0));
        cyc(exp_of(6'd6, 4'd5, 2'd1));
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        sb.push_back(exp_of(6'd0, 4'd0, 2'd0));
        cyc(exp_of(6'd0, 4'd0, 2'd0));
        reset_n = 1'b1;
        cyc(exp_of(6'd0, 4'd0, 2'd0));
        cyc(exp_of(6'd0, 4'd0, 2'd0));

        // Run B: full decryption with spurious inputs, then readout.
        load_and_init(1'b1);
        for (int r = 9; r >= 0; r--) begin
            if (r == 7) start_write_n = 1'b0;
            phase(6'd5, 4'(r));
            phase(6'd6, 4'(r));
            if (r == 6) start_write_n = 1'b1;
            phase(6'd7, 4'(r));
            if (r != 0) phase(6'd8, 4'(r));
        end
        for (int i = 0; i < 7; i++) cyc(exp_of(6'd9, 4'd0, 2'd0));
        start_read_n = 1'b0;
        phase(6'd10, 4'd0);
        for (int i = 0; i < 3; i++) cyc(exp_of(6'd0, 4'd0, 2'd0));
        start_read_n = 1'b1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end

        total = total + 1;
        if (done_cyc - e0 != 160) begin
            bad = bad + 1;
            $display("FAIL done_latency: got %0d cycles want 160", done_cyc - e0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_dec_state_manager.md
Name: aes_dec_state_manager

Overview:
Control FSM for the AES-128 inverse cipher (decryption). It sequences the shared 4x4 state matrix through these steps: ciphertext load, key load, round-key expansion wait, initial AddRoundKey (key 10), nine full inverse rounds, final inverse round (no InvMixColumns), then plaintext readout. It drives the matrix input mux, the row/column port selects, and the round-key index into the key store. It pairs with the encryption state manager and shares the same matrix datapath and key expansion unit.

Parameters:
NUM_ROUNDS, 10, AES-128 round count; last round key index = NUM_ROUNDS, loop runs NUM_ROUNDS-1 down to 0

Ports:
clock  in  1  system clock, all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
start_write_n  in  1  active-low; starts ciphertext/key write; sampled only in IDLE
start_read_n  in  1  active-low; starts plaintext readout; sampled only in DECRYPTION_DONE
key_expand_done  in  1  round keys 0..10 valid; sampled only in COMPUTE_ROUNDKEYS
done  out  1  high for every cycle in DECRYPTION_DONE
dbg_state  out  6  current state encoding
dbg_round  out  4  current round counter
matrix_in_sel  out  4  matrix write source: 0 ext input, 4 AddRoundKey, 5 InvSubBytes, 6 InvShiftRows, 7 InvMixColumns
matrix_write_enable  out  1  matrix write strobe
input_mat_row_col  out  1  write port: 0 row, 1 column
input_mat_idx  out  2  write port row/column index
output_mat_row_col  out  1  read port: 0 row, 1 column
output_mat_idx  out  2  read port row/column index
round_key_idx  out  4  round key selected for AddRoundKey (0..10)
key_start  out  1  one-cycle pulse to start key expansion
count_4_out  out  2  mirror of internal 4-step counter

Behaviour:
- Registers: state, round_counter[3:0], count_4[1:0]. Async reset sets IDLE, 0, 0. All outputs are combinational from these registers.
- Reset values: every output 0, dbg_state=0.
- Unspecified outputs in any state are driven to 0 (no X).
- State encodings: IDLE 0, CTEXT_WRITE 1, KEY_WRITE 2, COMPUTE_ROUNDKEYS 3, INIT_ADDROUNDKEY 4, INV_SHIFTROWS 5, INV_SUBBYTES 6, ADDROUNDKEY 7, INV_MIXCOLUMNS 8, DECRYPTION_DONE 9, PTEXT_READ 10. Unused codes go to IDLE with counters cleared.
- Four-step states (all except IDLE/COMPUTE/DONE): count_4 steps 0..3, then clears to 0 on exit. Both idx outputs = count_4 where driven.
- IDLE -> CTEXT_WRITE when start_write_n=0.
- CTEXT_WRITE: sel 0, we 1, in col. Exits to KEY_WRITE.
- KEY_WRITE: we 0, in row. key_start=1 only at count_4=0. Exits to COMPUTE_ROUNDKEYS.
- COMPUTE_ROUNDKEYS: holds until key_expand_done=1. On that edge goes to INIT_ADDROUNDKEY with round_counter=NUM_ROUNDS-1 (9).
- INIT_ADDROUNDKEY: sel 4, we 1, in/out col, round_key_idx=10. Exits to INV_SHIFTROWS.
- INV_SHIFTROWS: sel 6, we 1, in/out row. Exits to INV_SUBBYTES.
- INV_SUBBYTES: sel 5, we 1, in/out row. Exits to ADDROUNDKEY.
- ADDROUNDKEY: sel 4, we 1, in/out col, round_key_idx=round_counter.
  - If round_counter=0, exits to DECRYPTION_DONE.
  - Otherwise exits to INV_MIXCOLUMNS.
- INV_MIXCOLUMNS: sel 7, we 1, in/out col. Exits to INV_SHIFTROWS with round_counter-1.
- DECRYPTION_DONE: done=1, we 0. Goes to PTEXT_READ when start_read_n=0.
- PTEXT_READ: we 0, out col. Exits to IDLE; round_counter clears to 0.
- Latency: from the edge sampling key_expand_done=1 to the first DECRYPTION_DONE cycle is 4 + 9*16 + 12 = 160 cycles. Write phase is 8 cycles after start.
- Boundaries:
  - start_write_n low outside IDLE is ignored.
  - key_expand_done high before COMPUTE is ignored.
  - start_read_n held low continuously reruns nothing; the FSM returns to IDLE.
  - reset_n low in any state returns to IDLE asynchronously, outputs drop to 0 immediately.
- round_key_idx = 0 outside INIT_ADDROUNDKEY/ADDROUNDKEY.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state encodings (typedef enum logic [5:0]);
  - matrix_in_sel codes (MSEL_EXT, MSEL_ARK, MSEL_SB, MSEL_SR, MSEL_MC, MSEL_ISB, MSEL_ISR, MSEL_IMC);
  - NUM_ROUNDS.
- The package is shared with the encryption manager.
- Single module; no sub-module. The counter logic is too small to split out.

Test Plan:
- Reset mid-INV_SUBBYTES (round 5) -> next cycle dbg_state=0, dbg_round=0, all outputs 0; a fresh run then completes normally.
- start_write_n pulse -> 4 cycles sel=0/we=1/col idx 0..3; 4 cycles KEY_WRITE with key_start=1 only on first; then stall in state 3 with key_expand_done=0 for 20 cycles, we=0 throughout.
- key_expand_done=1 -> INIT_ADDROUNDKEY round_key_idx=10. Round 9 shows states 5,6,7,8 each 4 cycles, ADDROUNDKEY round_key_idx=9. Exactly 9 INV_MIXCOLUMNS phases.
- Final round -> ADDROUNDKEY round_key_idx=0, no state 8, DECRYPTION_DONE reached exactly 160 cycles after key_expand_done sample; done=1 held until start_read_n.
- start_read_n=0 after 7 idle cycles -> 4 cycles PTEXT_READ out col idx 0..3, we=0, then IDLE.
- Spurious start_write_n=0 during rounds and start_read_n=0 during CTEXT_WRITE -> no effect on the state sequence.
